// File: rtl/rv_branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_branch_pkg
//  Description : Shared constants for the RV32I branch resolution block:
//                branch funct3 codes, resolver FSM state encoding and the
//                width of the wrong-path squash counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_branch_pkg;

    // B-type condition select (funct3)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Wide enough for the largest supported squash length (7)
    localparam int SQ_CNT_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } br_state_t;

endpackage : rv_branch_pkg
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cmp
//  Description : Combinational RV32I branch condition evaluator.
//                Ports: rs1, rs2 (operands), funct3 (condition select),
//                take (1 = condition holds). Reserved codes 010/011 give 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cmp
    import rv_branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            take
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (rs1 == rs2);
    assign w_lt_s = ($signed(rs1) < $signed(rs2));
    assign w_lt_u = (rs1 < rs2);

    always_comb begin
        take = 1'b0;
        case (funct3)
            F3_BEQ:  take = w_eq;
            F3_BNE:  take = ~w_eq;
            F3_BLT:  take = w_lt_s;
            F3_BGE:  take = ~w_lt_s;
            F3_BLTU: take = w_lt_u;
            F3_BGEU: take = ~w_lt_u;
            default: take = 1'b0;
        endcase
    end

endmodule : branch_cmp
`default_nettype wire

// File: rtl/branch_resolve_rv32.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_rv32
//  Description : Execute-stage resolver for RV32I branches, JAL and JALR.
//                Produces a registered one-cycle redirect (branch,
//                branch_addr) to the PC unit, then discards SQUASH_CYCLES
//                cycles of wrong-path input while flush is high. Returns
//                pc+4 as link data for JAL/JALR and flags misaligned targets.
//  Ports       : clk, rst (sync, active-high)
//                ex_valid/ex_pc/ex_is_br/ex_is_jal/ex_is_jalr/ex_funct3/
//                ex_rs1/ex_rs2/ex_imm - instruction under resolution
//                branch, branch_addr  - redirect strobe and target
//                flush                - wrong-path discard window
//                link_valid, link_data- rd writeback for JAL/JALR
//                misalign_exc         - taken target not word aligned
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_rv32
    import rv_branch_pkg::*;
#(
    parameter int SQUASH_CYCLES = 2,
    parameter int XLEN          = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_br,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm,
    output logic            branch,
    output logic [XLEN-1:0] branch_addr,
    output logic            flush,
    output logic            link_valid,
    output logic [XLEN-1:0] link_data,
    output logic            misalign_exc
);

    localparam logic [SQ_CNT_W-1:0] C_SQ_LOAD = SQ_CNT_W'(SQUASH_CYCLES - 1);

    br_state_t           r_state;
    br_state_t           w_state_next;
    logic [SQ_CNT_W-1:0] r_sq_cnt;
    logic [SQ_CNT_W-1:0] w_sq_cnt_next;

    logic            w_take;
    logic            w_accept;
    logic            w_is_jump;
    logic            w_taken;
    logic            w_aligned;
    logic            w_redirect;
    logic [XLEN-1:0] w_pc_target;
    logic [XLEN-1:0] w_jalr_target;
    logic [XLEN-1:0] w_target;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .rs1    (ex_rs1),
        .rs2    (ex_rs2),
        .funct3 (ex_funct3),
        .take   (w_take)
    );

    // Inputs are only consumed while idle; anything arriving during the
    // squash window is wrong-path and silently dropped.
    assign w_accept  = ex_valid && (r_state == ST_IDLE);
    assign w_is_jump = ex_is_jal | ex_is_jalr;
    assign w_taken   = w_is_jump | (ex_is_br & w_take);

    assign w_pc_target   = ex_pc + ex_imm;
    assign w_jalr_target = (ex_rs1 + ex_imm) & ~XLEN'(1);

    // jal > jalr > br: JALR only selects its own target when JAL is clear
    assign w_target   = (ex_is_jalr && !ex_is_jal) ? w_jalr_target : w_pc_target;
    assign w_aligned  = (w_target[1:0] == 2'b00);
    assign w_redirect = w_accept && w_taken && w_aligned;

    // ------------------------------------------------------------------
    // Squash FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sq_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_sq_cnt <= w_sq_cnt_next;
        end
    end

    // Counter is loaded with SQUASH_CYCLES-1 so the SQUASH state, and with
    // it flush, lasts exactly SQUASH_CYCLES cycles.
    always_comb begin
        w_state_next  = r_state;
        w_sq_cnt_next = r_sq_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_redirect) begin
                    w_state_next  = ST_SQUASH;
                    w_sq_cnt_next = C_SQ_LOAD;
                end
            end
            ST_SQUASH: begin
                if (r_sq_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_sq_cnt_next = r_sq_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_sq_cnt_next = '0;
            end
        endcase
    end

    assign flush = (r_state == ST_SQUASH);

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            branch       <= 1'b0;
            branch_addr  <= '0;
            link_valid   <= 1'b0;
            link_data    <= '0;
            misalign_exc <= 1'b0;
        end else begin
            branch       <= w_redirect;
            misalign_exc <= w_accept && w_taken && !w_aligned;
            link_valid   <= w_accept && w_is_jump;
            // Target is reported for misaligned jumps too, so the trap
            // handler can see the faulting address.
            if (w_accept && w_taken) begin
                branch_addr <= w_target;
            end
            if (w_accept && w_is_jump) begin
                link_data <= ex_pc + XLEN'(4);
            end
        end
    end

endmodule : branch_resolve_rv32
`default_nettype wire

// File: tb/tb_branch_resolve_rv32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_rv32
//  Description : Self-checking bench for branch_resolve_rv32. Each cycle the
//                bench drives one input set, predicts the next-cycle outputs
//                with its own reference model and queues the prediction;
//                after the clock edge the prediction is popped and compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_rv32;

    localparam int C_SQ = 2;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_br;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_imm;
    logic        branch;
    logic [31:0] branch_addr;
    logic        flush;
    logic        link_valid;
    logic [31:0] link_data;
    logic        misalign_exc;

    typedef struct {
        logic        br;
        logic [31:0] addr;
        logic        fl;
        logic        lv;
        logic [31:0] ld;
        logic        mis;
    } exp_t;

    exp_t q_exp[$];
    int   r_checks;
    int   r_errors;
    int   m_sq_left;   // wrong-path cycles still to be discarded

    branch_resolve_rv32 #(
        .SQUASH_CYCLES (C_SQ),
        .XLEN          (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_is_br     (ex_is_br),
        .ex_is_jal    (ex_is_jal),
        .ex_is_jalr   (ex_is_jalr),
        .ex_funct3    (ex_funct3),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_imm       (ex_imm),
        .branch       (branch),
        .branch_addr  (branch_addr),
        .flush        (flush),
        .link_valid   (link_valid),
        .link_data    (link_data),
        .misalign_exc (misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        r_checks++;
        if (act !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive, predict, queue, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic [31:0] pc,
                        input logic br, input logic jal, input logic jalr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm);
        exp_t        e;
        exp_t        o;
        logic        tk;
        logic [31:0] tgt;
        @(negedge clk);
        rst = r; ex_valid = v; ex_pc = pc; ex_is_br = br; ex_is_jal = jal;
        ex_is_jalr = jalr; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_imm = imm;

        e.br = 1'b0; e.addr = '0; e.lv = 1'b0; e.ld = '0; e.mis = 1'b0;
        if (r) begin
            m_sq_left = 0;
        end else if (m_sq_left > 0) begin
            m_sq_left--;
        end else if (v) begin
            if (jal) begin
                tk = 1'b1; tgt = pc + imm;
            end else if (jalr) begin
                tk = 1'b1; tgt = (a + imm) & 32'hFFFF_FFFE;
            end else begin
                tk = br && cond(f3, a, b); tgt = pc + imm;
            end
            if (jal || jalr) begin
                e.lv = 1'b1; e.ld = pc + 32'd4;
            end
            if (tk) begin
                e.addr = tgt;
                if (tgt[1:0] == 2'b00) begin
                    e.br = 1'b1;
                    m_sq_left = C_SQ;
                end else begin
                    e.mis = 1'b1;
                end
            end
        end
        e.fl = (m_sq_left > 0);
        q_exp.push_back(e);

        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            o = q_exp.pop_front();
            chk("branch",       {31'd0, branch},       {31'd0, o.br});
            chk("flush",        {31'd0, flush},        {31'd0, o.fl});
            chk("link_valid",   {31'd0, link_valid},   {31'd0, o.lv});
            chk("misalign_exc", {31'd0, misalign_exc}, {31'd0, o.mis});
            if (o.br || o.mis) chk("branch_addr", branch_addr, o.addr);
            if (o.lv)          chk("link_data",   link_data,   o.ld);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        r_checks = 0; r_errors = 0; m_sq_left = 0;
        rst = 1'b1; ex_valid = 0; ex_pc = 0; ex_is_br = 0; ex_is_jal = 0;
        ex_is_jalr = 0; ex_funct3 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_imm = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h40, 1, 0, 0, 3'd0, 1, 1, 32'h8);
        idle(1);

        // BEQ taken, then BNE offered during the flush window is dropped
        step(0, 1, 32'h100, 1, 0, 0, 3'd0, 5, 5, 32'h20);
        step(0, 1, 32'h104, 1, 0, 0, 3'd1, 1, 2, 32'h40);
        step(0, 1, 32'h108, 1, 0, 0, 3'd1, 1, 2, 32'h40);
        idle(2);

        // Signed vs unsigned compare on the same operands
        step(0, 1, 32'h180, 1, 0, 0, 3'd4, 32'hFFFF_FFFF, 1, 32'h10);
        idle(2);
        step(0, 1, 32'h180, 1, 0, 0, 3'd6, 32'hFFFF_FFFF, 1, 32'h10);
        idle(1);

        // Reserved funct3 codes are never taken
        step(0, 1, 32'h1C0, 1, 0, 0, 3'd2, 7, 7, 32'h3);
        step(0, 1, 32'h1C0, 1, 0, 0, 3'd3, 7, 7, 32'h3);

        // JALR clears bit 0 of the target
        step(0, 1, 32'h200, 0, 0, 1, 3'd0, 32'h1003, 0, 0);
        idle(2);

        // JAL to a misaligned target: exception, link still written, no flush
        step(0, 1, 32'h300, 0, 1, 0, 3'd0, 0, 0, 32'h6);
        idle(1);

        // JAL beats JALR and a failing branch when several flags are set
        step(0, 1, 32'h400, 1, 1, 1, 3'd1, 3, 3, 32'h40);
        idle(2);

        // Back-to-back taken BEQs: only the first redirects
        step(0, 1, 32'h500, 1, 0, 0, 3'd0, 9, 9, 32'h10);
        step(0, 1, 32'h504, 1, 0, 0, 3'd0, 9, 9, 32'h20);
        idle(2);

        // Reset during the first squash cycle, then a normal redirect
        step(0, 1, 32'h600, 1, 0, 0, 3'd0, 1, 1, 32'h40);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h700, 1, 0, 0, 3'd5, 3, 2, 32'hFFFF_FFF0);
        idle(3);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [1:0] kind;
            logic [31:0] imm;
            kind = 2'($urandom_range(0, 3));
            imm  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 $urandom & 32'hFFFF_FFFC,
                 (kind == 0) || ($urandom_range(0, 7) == 0),
                 (kind == 1), (kind == 2),
                 3'($urandom_range(0, 7)),
                 32'($urandom_range(0, 3)) - 32'd1, 32'($urandom_range(0, 3)) - 32'd1,
                 imm);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule : tb_branch_resolve_rv32
`default_nettype wire
